// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// vector layout, the width of the source index, and the vector address helper.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVICE = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  localparam logic [15:0] INT_VEC_BASE   = 16'h0010;
  localparam logic [15:0] INT_VEC_STRIDE = 16'h0004;

  // Up to 8 sources, so a 3-bit index covers every configuration.
  localparam int ID_W = 3;

  // Handler address for a source; wraps modulo 2^16 by construction.
  function automatic logic [15:0] vec_addr(input logic [15:0]     base,
                                           input logic [15:0]     stride,
                                           input logic [ID_W-1:0] id);
    return base + stride * {{(16-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc
  import cpu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx,
  output logic [N-1:0]    onehot
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid     = 1'b1;
        idx       = ID_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller for the execute stage: latches rising edges from the
// sources, masks and prioritises them, fires one entry pulse when the pipeline
// can take it, and holds in-service state until the handler's ret. No nesting:
// execute keeps a single saved PC.
module int_ctrl
  import cpu_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = INT_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = INT_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_mask,
  input  logic               pipe_ok,
  input  logic               ret_in,
  output logic               int_fire,
  output logic [15:0]        int_vec,
  output logic               int_state,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [7:0]         overrun_cnt
);

  logic [NUM_SRC-1:0] req_q, req_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_d;
  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [7:0]         ovr_q, ovr_d;

  logic [NUM_SRC-1:0] req_rise;
  logic [NUM_SRC-1:0] eligible;
  logic               win_vld;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_SRC-1:0] win_onehot;

  assign req_rise = irq_req & ~req_q;
  assign eligible = pending_q & ~mask_q;

  prio_enc #(
    .N (NUM_SRC)
  ) u_prio (
    .req    (eligible),
    .valid  (win_vld),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  // Entry/return sequencing; the fire pulse, ack and vector are combinational
  // so execute sees them in the same cycle the decision is made.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    int_fire    = 1'b0;
    irq_ack     = '0;
    int_vec     = '0;
    case (state_q)
      ST_IDLE: begin
        // ret_in here is an ordinary subroutine return and must not block
        // nor be confused with a handler exit, but it does hold off entry.
        if (win_vld && pipe_ok && !ret_in) begin
          int_fire    = 1'b1;
          irq_ack     = win_onehot;
          int_vec     = vec_addr(VEC_BASE, VEC_STRIDE, win_idx);
          active_id_d = win_idx;
          state_d     = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (ret_in) state_d = ST_GAP;
      end
      // One quiet cycle lets the instruction at the restored PC retire.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge capture, pending set/clear (a new edge beats a same-cycle ack),
  // mask write and the saturating lost-event counter.
  always_comb begin
    req_d     = irq_req;
    pending_d = (pending_q & ~irq_ack) | req_rise;
    mask_d    = cfg_we ? cfg_mask : mask_q;
    ovr_d     = ovr_q;
    if ((|(req_rise & pending_q & ~irq_ack)) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // State registers; reset drops any pending or in-service interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      state_q     <= ST_IDLE;
      active_id_q <= '0;
      ovr_q       <= '0;
    end else begin
      req_q       <= req_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      state_q     <= state_d;
      active_id_q <= active_id_d;
      ovr_q       <= ovr_d;
    end
  end

  assign int_state   = (state_q == ST_SERVICE);
  assign active_id   = active_id_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the controller's rules.
module tb_int_ctrl;

  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] irq;
  logic          we;
  logic [NS-1:0] cmask;
  logic          pok;
  logic          ret;
  logic          int_fire;
  logic [15:0]   int_vec;
  logic          int_state;
  logic [NS-1:0] irq_ack;
  logic [2:0]    active_id;
  logic [NS-1:0] mask_o;
  logic [7:0]    overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit [NS-1:0] m_pend, m_mask, m_prev;
  bit          m_busy, m_gap;
  int          m_active, m_ovr;

  int_ctrl #(
    .NUM_SRC    (NS),
    .VEC_BASE   (16'h0010),
    .VEC_STRIDE (16'h0004)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .irq_req     (irq),
    .cfg_we      (we),
    .cfg_mask    (cmask),
    .pipe_ok     (pok),
    .ret_in      (ret),
    .int_fire    (int_fire),
    .int_vec     (int_vec),
    .int_state   (int_state),
    .irq_ack     (irq_ack),
    .active_id   (active_id),
    .mask_q      (mask_o),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_busy = 1'b0; m_gap = 1'b0; m_active = 0; m_ovr = 0;
  endtask

  // Compare one cycle at the falling edge, then advance the model across the
  // rising edge; returns 1 time unit after the rising edge.
  task automatic cycle();
    int          win;
    bit          fire, ovf;
    bit [NS-1:0] elig, ack, rise;
    logic [31:0] exp_vec;
    @(negedge clk);
    elig = m_pend & ~m_mask;
    win  = -1;
    for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;
    fire    = !m_busy && !m_gap && (win >= 0) && pok && !ret;
    ack     = '0;
    exp_vec = 32'd0;
    if (fire) begin
      ack[win] = 1'b1;
      exp_vec  = (32'h0010 + 32'd4 * 32'(win)) & 32'hFFFF;
    end
    check_eq("fire",   32'(int_fire),    32'(fire));
    check_eq("ack",    32'(irq_ack),     32'(ack));
    check_eq("vec",    32'(int_vec),     exp_vec);
    check_eq("state",  32'(int_state),   32'(m_busy));
    check_eq("active", 32'(active_id),   32'(m_active));
    check_eq("mask",   32'(mask_o),      32'(m_mask));
    check_eq("ovr",    32'(overrun_cnt), 32'(m_ovr));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rise   = irq & ~m_prev;
      ovf    = |(rise & m_pend & ~ack);
      m_pend = (m_pend & ~ack) | rise;
      if (ovf && m_ovr < 255) m_ovr++;
      m_prev = irq;
      if (we) m_mask = cmask;
      if (fire) begin
        m_busy   = 1'b1;
        m_active = win;
      end else if (m_busy) begin
        if (ret) begin
          m_busy = 1'b0;
          m_gap  = 1'b1;
        end
      end else begin
        m_gap = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; irq = '0; we = 1'b0; cmask = '0; pok = 1'b0; ret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_state", 32'(int_state), 32'd0);
    check_eq("rst_fire",  32'(int_fire), 32'd0);
    check_eq("rst_ovr",   32'(overrun_cnt), 32'd0);
    check_eq("rst_mask",  32'(mask_o), 32'd0);
    check_eq("rst_pend",  32'(u_dut.pending_q), 32'd0);

    // Single source 2
    pok = 1'b1; irq = 4'b0100; cycle();
    irq = '0; #1;
    check_eq("t1_fire", 32'(int_fire), 32'd1);
    check_eq("t1_ack",  32'(irq_ack), 32'b0100);
    check_eq("t1_vec",  32'(int_vec), 32'h0018);
    cycle(); #1;
    check_eq("t1_state",  32'(int_state), 32'd1);
    check_eq("t1_active", 32'(active_id), 32'd2);
    cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; cycle(); cycle();

    // Sources 3 and 1 together
    irq = 4'b1010; cycle();
    irq = '0; #1;
    check_eq("t2_vec1", 32'(int_vec), 32'h0014);
    cycle(); cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; #1;
    check_eq("t2_gap", 32'(int_fire), 32'd0);
    cycle(); #1;
    check_eq("t2_fire3", 32'(int_fire), 32'd1);
    check_eq("t2_vec3",  32'(int_vec), 32'h001C);
    cycle(); cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; cycle(); cycle();

    // Masked source 0
    we = 1'b1; cmask = 4'b0001; cycle();
    we = 1'b0; irq = 4'b0001; cycle();
    irq = '0; #1;
    check_eq("t3_masked", 32'(int_fire), 32'd0);
    cycle(); cycle();
    we = 1'b1; cmask = 4'b0000; #1;
    check_eq("t3_mask_wr", 32'(int_fire), 32'd0);
    cycle();
    we = 1'b0; #1;
    check_eq("t3_unmask", 32'(int_fire), 32'd1);
    cycle(); cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; cycle(); cycle();

    // Pipeline not ready for 5 cycles
    pok = 1'b0; irq = 4'b1000; cycle();
    irq = '0;
    repeat (5) begin
      #1;
      check_eq("t4_hold", 32'(int_fire), 32'd0);
      cycle();
    end
    pok = 1'b1; #1;
    check_eq("t4_fire", 32'(int_fire), 32'd1);
    check_eq("t4_vec",  32'(int_vec), 32'h001C);
    cycle(); cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; #1;
    check_eq("t4_ret_idle", 32'(int_state), 32'd0);
    cycle();

    // Overruns on source 1
    pok = 1'b0;
    repeat (3) begin
      irq = 4'b0010; cycle();
      irq = '0;      cycle();
    end
    #1;
    check_eq("t5_ovr2", 32'(overrun_cnt), 32'd2);
    repeat (300) begin
      irq = 4'b0010; cycle();
      irq = '0;      cycle();
    end
    #1;
    check_eq("t5_sat", 32'(overrun_cnt), 32'd255);
    pok = 1'b1; cycle(); cycle();
    ret = 1'b1; cycle();
    ret = 1'b0; cycle(); cycle();

    // Reset during service
    we = 1'b1; cmask = 4'b1000; cycle();
    we = 1'b0; irq = 4'b0001; cycle();
    irq = '0; #1;
    check_eq("t6_fire", 32'(int_fire), 32'd1);
    cycle(); #1;
    check_eq("t6_svc", 32'(int_state), 32'd1);
    irq = 4'b0100; cycle();
    irq = '0; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; #1;
    check_eq("t6_state", 32'(int_state), 32'd0);
    check_eq("t6_pend",  32'(u_dut.pending_q), 32'd0);
    check_eq("t6_mask",  32'(mask_o), 32'd0);
    check_eq("t6_ovr",   32'(overrun_cnt), 32'd0);
    repeat (4) cycle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < NS; b++) if (($urandom % 4) == 0) irq[b] = ~irq[b];
      pok   = (($urandom % 4) != 0);
      ret   = (($urandom % 5) == 0);
      we    = (($urandom % 16) == 0);
      cmask = NS'($urandom);
      rst   = (($urandom % 200) == 0);
      cycle();
    end
    rst = 1'b0; we = 1'b0; ret = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
